// File: rtl/request_arbiter.sv
// request_arbiter: gives NREQ requesters one holding slot each and drains the
// occupied slots into a shared request FIFO in round-robin order. The FIFO's
// full/almost_full flags gate every issue, so the FIFO can never overflow.
// A small RUN/STALL machine adds hysteresis so that flapping flags do not
// cause start/stop chatter on the write port.
module request_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 12,
  parameter int IDW    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     full,
  input  logic                     almost_full,
  output logic [DATA_W-1:0]        dataIn,
  output logic                     write,
  output logic [IDW-1:0]           write_src
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t                      state_r;
  state_t                      state_s;
  logic [1:0]                  clr_cnt_r;
  logic [1:0]                  clr_cnt_s;
  logic [2:0]                  af_cnt_r;
  logic [2:0]                  af_cnt_s;

  logic [NREQ-1:0]             slot_valid_r;
  logic [NREQ-1:0][DATA_W-1:0] slot_data_r;
  logic [IDW-1:0]              rr_r;

  logic                        issue_ok_s;
  logic                        pick_found_s;
  logic [IDW-1:0]              pick_idx_s;
  logic                        issue_s;

  // First occupied slot at or after 'start', wrapping; the MSB of the result
  // flags whether any slot was occupied at all.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  start);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] sel;
    logic           found;
    found = 1'b0;
    sel   = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx = start + IDW'(k);
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  // A slot is free exactly when it holds nothing; this is a pure register view.
  assign req_ready = ~slot_valid_r;

  // State register plus the consecutive-cycle counters used for hysteresis.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_RUN;
      clr_cnt_r <= 2'd0;
      af_cnt_r  <= 3'd0;
    end else begin
      state_r   <= state_s;
      clr_cnt_r <= clr_cnt_s;
      af_cnt_r  <= af_cnt_s;
    end
  end

  // Next state: stall on full; leave after 2 clear cycles or 4 almost-full cycles.
  always_comb begin
    state_s   = state_r;
    clr_cnt_s = 2'd0;
    af_cnt_s  = 3'd0;
    case (state_r)
      ST_RUN: begin
        if (full) begin
          state_s = ST_STALL;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STALL: begin
        if (full) begin
          state_s = ST_STALL;
        end else if (!almost_full) begin
          if (clr_cnt_r == 2'd1) begin
            state_s = ST_RUN;
          end else begin
            clr_cnt_s = clr_cnt_r + 2'd1;
          end
        end else begin
          if (af_cnt_r == 3'd3) begin
            state_s = ST_RUN;
          end else begin
            af_cnt_s = af_cnt_r + 3'd1;
          end
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Issue decision: a write in flight may take the last free entry, so wait.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(slot_valid_r, rr_r);
    if ((state_r == ST_RUN) && !full && !(almost_full && write)) begin
      issue_ok_s = 1'b1;
    end else begin
      issue_ok_s = 1'b0;
    end
    if (issue_ok_s && pick_found_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Slot capture and release; capture only ever targets an empty slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_r <= {NREQ{1'b0}};
      slot_data_r  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (issue_s && (pick_idx_s == IDW'(i))) begin
          slot_valid_r[i] <= 1'b0;
        end else if (req_write[i] && !slot_valid_r[i]) begin
          slot_valid_r[i] <= 1'b1;
          slot_data_r[i]  <= req_data[i*DATA_W +: DATA_W];
        end else begin
          slot_valid_r[i] <= slot_valid_r[i];
        end
      end
    end
  end

  // Registered FIFO write port and round-robin pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataIn    <= {DATA_W{1'b0}};
      write     <= 1'b0;
      write_src <= {IDW{1'b0}};
      rr_r      <= {IDW{1'b0}};
    end else if (issue_s) begin
      dataIn    <= slot_data_r[pick_idx_s];
      write     <= 1'b1;
      write_src <= pick_idx_s;
      rr_r      <= pick_idx_s + IDW'(1);
    end else begin
      write     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_request_arbiter.sv
// Testbench for request_arbiter: scoreboard of expected (source, word) pairs
// pushed when a requester is driven, popped whenever the FIFO port writes.
module tb_request_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 full;
  logic                 almost_full;
  logic [DW-1:0]        dataIn;
  logic                 write;
  logic [IDW-1:0]       write_src;

  logic [IDW+DW-1:0]    sb[$];
  logic [IDW+DW-1:0]    exp_word;
  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   cnt;

  request_arbiter #(.NREQ(NREQ), .DATA_W(DW), .IDW(IDW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_write   (req_write),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .almost_full (almost_full),
    .dataIn      (dataIn),
    .write       (write),
    .write_src   (write_src)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one requester this cycle and record the word it should produce.
  task automatic load(input int i, input logic [DW-1:0] d, input bit expect_out);
    req_data[i*DW +: DW] = d;
    req_write[i] = 1'b1;
    if (expect_out) sb.push_back({IDW'(i), d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_eq("sb_empty_before_reset", 32'(sb.size()), 32'd0);
    reset = 1'b0;
    req_write = '0;
    full = 1'b0;
    almost_full = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'hF);
    check_eq("rst_write", 32'(write), 32'd0);
    reset = 1'b1;
  endtask

  // Scoreboard: every FIFO write must match the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && write === 1'b1) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        check_eq("write_src", 32'(write_src), 32'(exp_word[IDW+DW-1:DW]));
        check_eq("dataIn", 32'(dataIn), 32'(exp_word[DW-1:0]));
      end
    end
  end

  initial begin
    reset = 1'b0;
    req_write = '0;
    req_data = '0;
    full = 1'b0;
    almost_full = 1'b0;
    #12;
    check_eq("reset_write", 32'(write), 32'd0);
    check_eq("reset_dataIn", 32'(dataIn), 32'd0);
    check_eq("reset_src", 32'(write_src), 32'd0);
    check_eq("reset_ready", 32'(req_ready), 32'hF);
    @(negedge clk);
    reset = 1'b1;

    // 1: single request, plus an illegal write while the slot is busy
    @(negedge clk);
    load(0, 12'h0A5, 1'b1);
    @(negedge clk);
    check_eq("t1_ready_low", 32'(req_ready), 32'hE);
    load(0, 12'h777, 1'b0);
    @(negedge clk);
    req_write = '0;
    check_eq("t1_write", 32'(write), 32'd1);
    check_eq("t1_data", 32'(dataIn), 32'h0A5);
    check_eq("t1_ready_back", 32'(req_ready), 32'hF);
    @(negedge clk);
    check_eq("t1_write_drop", 32'(write), 32'd0);
    check_eq("t1_data_hold", 32'(dataIn), 32'h0A5);
    cyc(2);

    // 2: all four at once from rr=0, back-to-back
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) load(i, 12'h100 + 12'(i), 1'b1);
    @(negedge clk);
    req_write = '0;
    for (int i = 0; i < NREQ; i++) begin
      @(negedge clk);
      check_eq("t2_b2b_write", 32'(write), 32'd1);
    end
    @(negedge clk);
    check_eq("t2_write_end", 32'(write), 32'd0);
    // rr must be back at 0: slot 0 beats slot 3
    load(3, 12'h203, 1'b0);
    load(0, 12'h200, 1'b1);
    sb.push_back({IDW'(3), 12'h203});
    @(negedge clk);
    req_write = '0;
    cyc(4);

    // 3: fairness between requesters 1 and 3 rewriting whenever ready
    do_reset();
    cnt = 0;
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      req_write = '0;
      for (int k = 1; k < NREQ; k += 2) begin
        if (req_ready[k]) begin
          load(k, 12'h300 + 12'(cnt), 1'b1);
          cnt++;
        end
      end
    end
    @(negedge clk);
    req_write = '0;
    cyc(4);

    // 4: almost_full forces a gap after each write
    do_reset();
    almost_full = 1'b1;
    @(negedge clk);
    load(0, 12'h400, 1'b1);
    load(2, 12'h402, 1'b1);
    @(negedge clk);
    req_write = '0;
    check_eq("t4_n1", 32'(write), 32'd0);
    @(negedge clk);
    check_eq("t4_first", 32'(write), 32'd1);
    @(negedge clk);
    check_eq("t4_gap", 32'(write), 32'd0);
    @(negedge clk);
    check_eq("t4_second", 32'(write), 32'd1);
    @(negedge clk);
    almost_full = 1'b0;
    check_eq("t4_after", 32'(write), 32'd0);

    // 5a: full for 5 cycles, resume 2 clear cycles later
    do_reset();
    @(negedge clk);
    full = 1'b1;
    for (int i = 0; i < 3; i++) load(i, 12'h500 + 12'(i), 1'b1);
    for (int it = 0; it < 5; it++) begin
      @(negedge clk);
      req_write = '0;
      check_eq("t5_stall", 32'(write), 32'd0);
    end
    full = 1'b0;
    @(negedge clk);
    check_eq("t5_hyst1", 32'(write), 32'd0);
    @(negedge clk);
    check_eq("t5_hyst2", 32'(write), 32'd0);
    @(negedge clk);
    check_eq("t5_resume", 32'(write), 32'd1);
    cyc(3);

    // 5b: leaving STALL through 4 cycles of almost_full only
    @(negedge clk);
    full = 1'b1;
    load(3, 12'h5A3, 1'b1);
    @(negedge clk);
    req_write = '0;
    full = 1'b0;
    almost_full = 1'b1;
    check_eq("t5b_stall", 32'(write), 32'd0);
    for (int it = 0; it < 4; it++) begin
      @(negedge clk);
      check_eq("t5b_af_wait", 32'(write), 32'd0);
    end
    @(negedge clk);
    check_eq("t5b_resume", 32'(write), 32'd1);
    almost_full = 1'b0;
    cyc(2);

    // 6: asynchronous reset mid-stream discards buffered words
    do_reset();
    @(negedge clk);
    load(0, 12'h600, 1'b1);
    load(1, 12'h601, 1'b0);
    load(2, 12'h602, 1'b0);
    @(negedge clk);
    req_write = '0;
    @(negedge clk);
    check_eq("t6_inflight", 32'(write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_async_write", 32'(write), 32'd0);
    check_eq("t6_async_ready", 32'(req_ready), 32'hF);
    check_eq("t6_async_data", 32'(dataIn), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc(6);

    // Bounded drain of anything still expected
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
